mem_access_unit: RTL

//  Bus-side memory stage consuming the multi-cycle controller's mem_re/mem_we strobes (fetch and load/store).

---
 rtl/frost_mem_pkg.sv | 59 +++++
 rtl/mem_lane_align.sv | 21 ++
 rtl/mem_access_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/frost_mem_pkg.sv
// Shared encodings and lane helpers for the bus-side memory stage.
package frost_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } mem_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } mau_state_e;

  // Fetches are always words; the reserved size code 11 behaves as a word.
  function automatic mem_size_e decode_size(input logic fetch, input logic [1:0] f3_sz);
    if (fetch) return SZ_W;
    case (f3_sz)
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] lane_strb(input mem_size_e sz, input logic [1:0] a_lo);
    case (sz)
      SZ_B:    return 4'b0001 << a_lo;
      SZ_H:    return a_lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input mem_size_e sz, input logic [31:0] d);
    case (sz)
      SZ_B:    return {4{d[7:0]}};
      SZ_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input mem_size_e sz, input logic zext,
                                               input logic [1:0] a_lo, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (a_lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a_lo[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_B:    return zext ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_H:    return zext ? {16'b0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational store lane steering and load extraction/extension.
module mem_lane_align
  import frost_mem_pkg::*;
(
  input  mem_size_e   st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  output logic [31:0] st_wdata_lane,
  input  mem_size_e   ld_size,
  input  logic        ld_zext,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  assign st_wstrb      = lane_strb(st_size, st_addr_lo);
  assign st_wdata_lane = lane_data(st_size, st_wdata);
  assign ld_data       = load_extract(ld_size, ld_zext, ld_addr_lo, ld_word);

endmodule

// File: rtl/mem_access_unit.sv
// Bus-side memory stage: latches one controller request, runs a valid/ready
// bus transaction with timeout, and stalls the controller until completion.
// Optional build macro MEM_MISALIGN_TRAP_EN adds a misalign trap output.
module mem_access_unit
  import frost_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic        inst_fetch,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        bus_err,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
`ifdef MEM_MISALIGN_TRAP_EN
  input  logic [31:0] bus_rdata,
  output logic        misalign
`else
  input  logic [31:0] bus_rdata
`endif
);

  mau_state_e  state_q, state_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  mem_size_e   size_q, size_d;
  logic        zext_q, zext_d;
  logic        we_q, we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] tmo_q, tmo_d;
  logic        stall_c;
  logic        trap_c;
  logic        req;
  logic        timeout;
  mem_size_e   req_size;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata_lane;
  logic [31:0] ld_data;

  assign req      = mem_re | mem_we;
  assign req_size = decode_size(inst_fetch, funct3[1:0]);
  // A zero limit disables the timeout entirely.
  assign timeout  = (TIMEOUT_CYCLES != 0) && (tmo_q == 32'(TIMEOUT_CYCLES - 1));

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((req_size == SZ_H) && addr[0]) ||
                      ((req_size == SZ_W) && (addr[1:0] != 2'b00));
  assign trap_c     = (state_q == ST_IDLE) && req && misaligned;
  assign misalign   = trap_c & ~reset;
`else
  assign trap_c = 1'b0;
`endif

  mem_lane_align u_lane (
    .st_size       (req_size),
    .st_addr_lo    (addr[1:0]),
    .st_wdata      (wdata),
    .st_wstrb      (st_wstrb),
    .st_wdata_lane (st_wdata_lane),
    .ld_size       (size_q),
    .ld_zext       (zext_q),
    .ld_addr_lo    (addr_lo_q),
    .ld_word       (bus_rdata),
    .ld_data       (ld_data)
  );

  // Next-state, request latching and completion handling.
  always_comb begin
    state_d     = state_q;
    addr_lo_d   = addr_lo_q;
    size_d      = size_q;
    zext_d      = zext_q;
    we_d        = we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    rdata_d     = rdata_q;
    bus_err_d   = 1'b0;
    tmo_d       = tmo_q;
    stall_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req && !trap_c) begin
          state_d     = ST_REQ;
          addr_lo_d   = addr[1:0];
          size_d      = req_size;
          zext_d      = inst_fetch | funct3[2];
          we_d        = mem_we;
          bus_addr_d  = {addr[31:2], 2'b00};
          bus_wdata_d = st_wdata_lane;
          bus_wstrb_d = mem_we ? st_wstrb : 4'b0000;
          tmo_d       = '0;
          stall_c     = 1'b1;
        end
      end
      ST_REQ: begin
        if (bus_ready) begin
          state_d = ST_IDLE;
          if (!we_q) rdata_d = ld_data;
        end else if (timeout) begin
          state_d   = ST_IDLE;
          bus_err_d = 1'b1;
          rdata_d   = '0;
        end else begin
          tmo_d   = tmo_q + 32'd1;
          stall_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any pending request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_lo_q   <= '0;
      size_q      <= SZ_B;
      zext_q      <= 1'b0;
      we_q        <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      rdata_q     <= '0;
      bus_err_q   <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_lo_q   <= addr_lo_d;
      size_q      <= size_d;
      zext_q      <= zext_d;
      we_q        <= we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      rdata_q     <= rdata_d;
      bus_err_q   <= bus_err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign bus_valid = (state_q == ST_REQ);
  assign stall     = stall_c & ~reset;
  assign bus_we    = we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wstrb = bus_wstrb_q;
  assign rdata     = rdata_q;
  assign bus_err   = bus_err_q;

endmodule
